// File: rtl/conv_tile_feeder.sv
// Byte-stream front end for one 3x3-over-4x4 convolution engine: loads a tile, runs the engine, streams back 4 results.
// Optional RUN watchdog enabled by defining CONV_FEED_TIMEOUT_EN.
module conv_tile_feeder #(
  parameter int ENGINE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [127:0] mat_flat,
  output logic [71:0]  kern_flat,
  output logic         eng_rst,
  input  logic         done_in,
  input  logic [31:0]  res_in,
  output logic [7:0]   m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_SEND} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [4:0]         r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_j;
  logic [31:0]        r_res;
  logic [127:0]       r_mat;
  logic [71:0]        r_kern;

  logic               w_in_xfer;
  logic               w_eng_ok;
  logic               w_timeout;
  logic [6:0]         w_bofs;

  assign w_in_xfer = s_valid && s_ready;
  // done_in is sticky in the engine, so it only counts once the minimum run time has elapsed
  assign w_eng_ok  = (r_state == ST_RUN) && (r_cnt >= CNT_W'(ENGINE_CYCLES)) && done_in;
  // bytes 16..24 land in kern slots 0..8, which is exactly the low nibble of the index
  assign w_bofs    = {r_idx[3:0], 3'b000};

`ifdef CONV_FEED_TIMEOUT_EN
  assign w_timeout = (r_state == ST_RUN) && !w_eng_ok && (r_cnt >= CNT_W'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  assign mat_flat  = r_mat;
  assign kern_flat = r_kern;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD: if (w_in_xfer && (r_idx == 5'd24)) w_next = ST_RUN;
      ST_RUN: begin
        if (w_eng_ok)       w_next = ST_SEND;
        else if (w_timeout) w_next = ST_LOAD;
      end
      ST_SEND: if (m_ready && (r_j == 2'd3)) w_next = ST_LOAD;
      default: w_next = ST_LOAD;
    endcase
  end

  always_comb begin
    s_ready     = (r_state == ST_LOAD) && rst;
    eng_rst     = (r_state != ST_RUN);
    m_valid     = (r_state == ST_SEND);
    m_last      = (r_state == ST_SEND) && (r_j == 2'd3);
    m_data      = 8'h00;
    err_timeout = w_timeout;
    if (r_state == ST_SEND) m_data = r_res[{r_j, 3'b000} +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_j    <= '0;
      r_res  <= '0;
      r_mat  <= '0;
      r_kern <= '0;
    end else begin
      if (w_in_xfer) begin
        if (r_idx[4]) r_kern[w_bofs +: 8] <= s_data;
        else          r_mat[w_bofs +: 8]  <= s_data;
        r_idx <= (r_idx == 5'd24) ? 5'd0 : r_idx + 5'd1;
      end
      // cleared whenever not running, so every RUN starts counting from zero
      if (r_state == ST_RUN) begin
        if (!(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (w_eng_ok) r_res <= res_in;
      if ((r_state == ST_SEND) && m_ready) r_j <= r_j + 2'd1;
    end
  end

endmodule

// File: tb/tb_conv_tile_feeder.sv
// Directed bench for conv_tile_feeder with a behavioural convolution engine driving res_in.
module tb_conv_tile_feeder;

  logic         clk;
  logic         rst;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] mat_flat;
  logic [71:0]  kern_flat;
  logic         eng_rst;
  logic         done_in;
  logic [31:0]  res_in;
  logic [7:0]   m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic         err_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [71:0] KERN_ONES = 72'h01_01_01_01_01_01_01_01_01;
  localparam logic [71:0] KERN_TWOS = 72'h02_02_02_02_02_02_02_02_02;
  localparam logic [71:0] KERN_K11  = 72'h00_00_00_00_00_00_00_00_01;
  localparam logic [31:0] EXP_ONES  = {8'd99, 8'd90, 8'd63, 8'd54};
  localparam logic [31:0] EXP_TWOS  = {8'd198, 8'd180, 8'd126, 8'd108};
  localparam logic [31:0] EXP_K11   = {8'd16, 8'd15, 8'd12, 8'd11};

  conv_tile_feeder dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mat_flat(mat_flat), .kern_flat(kern_flat), .eng_rst(eng_rst), .done_in(done_in),
    .res_in(res_in), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // engine stand-in: the real engine rotates the kernel by 180 degrees and wraps to 8 bits
  function automatic logic [7:0] conv_px(input logic [127:0] m, input logic [71:0] k,
                                         input int oi, input int oj);
    logic [7:0] acc;
    acc = 8'd0;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        acc = acc + 8'(m[8*((oi+a)*4+oj+b) +: 8] * k[8*((2-a)*3+(2-b)) +: 8]);
    return acc;
  endfunction

  always_comb begin
    res_in = {conv_px(mat_flat, kern_flat, 1, 1), conv_px(mat_flat, kern_flat, 1, 0),
              conv_px(mat_flat, kern_flat, 0, 1), conv_px(mat_flat, kern_flat, 0, 0)};
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_tile(input logic [71:0] kern);
    chk("load_s_ready", s_ready, 1);
    chk("load_eng_rst", eng_rst, 1);
    for (int k = 0; k < 25; k++) begin
      s_valid = 1'b1;
      if (k < 16) s_data = 8'(k + 1);
      else        s_data = kern[8*(k-16) +: 8];
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_data  = 8'h00;
    chk("tile_mat_11", mat_flat[7:0], 1);
    chk("tile_mat_44", mat_flat[127:120], 16);
    chk("tile_kern", kern_flat, kern);
    chk("run_s_ready", s_ready, 0);
    chk("run_eng_rst", eng_rst, 0);
  endtask

  task automatic get_results(input logic [31:0] exp, input int stall, input int done_at,
                             input int exp_lat);
    int j;
    int cyc;
    int lat;
    j = 0; cyc = 0; lat = -1;
    while (j < 4 && cyc < 3000) begin
      if (cyc == done_at) done_in = 1'b1;
      if (cyc >= 3 && cyc < 8) begin
        s_valid = 1'b1;
        s_data  = 8'hEE;
      end else begin
        s_valid = 1'b0;
      end
      m_ready = (stall == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (m_valid) begin
        if (lat < 0) begin
          lat = cyc;
          chk("send_eng_rst", eng_rst, 1);
        end
        chk("m_data", m_data, exp[8*j +: 8]);
        chk("m_last", m_last, (j == 3));
        if (m_ready) j++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b0;
    s_valid = 1'b0;
    chk("results_count", j, 4);
    chk("latency", lat, exp_lat);
    chk("after_m_valid", m_valid, 0);
    chk("after_m_last", m_last, 0);
    chk("after_s_ready", s_ready, 1);
    chk("junk_ignored", mat_flat[7:0], 1);
  endtask

  initial begin
    rst = 1'b0; s_data = 8'h00; s_valid = 1'b0; done_in = 1'b0; m_ready = 1'b0;
    #2;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_eng_rst", eng_rst, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_mat", mat_flat, 0);
    chk("rst_kern", kern_flat, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // all-ones kernel, done already high
    done_in = 1'b1;
    load_tile(KERN_ONES);
    get_results(EXP_ONES, 0, 0, 65);

    // single-tap kernel, done arrives late
    done_in = 1'b0;
    load_tile(KERN_K11);
    get_results(EXP_K11, 0, 100, 101);

    // downstream stalls two of every three cycles
    load_tile(KERN_ONES);
    get_results(EXP_ONES, 1, 0, 65);

    // back-to-back tiles with sticky done
    load_tile(KERN_ONES);
    get_results(EXP_ONES, 0, 0, 65);
    load_tile(KERN_TWOS);
    get_results(EXP_TWOS, 0, 0, 65);

    // reset in the middle of loading
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'b1;
      s_data  = 8'(k + 40);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst = 1'b0;
    #2;
    chk("midrst_eng_rst", eng_rst, 1);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_mat", mat_flat, 0);
    chk("midrst_kern", kern_flat, 0);
    @(posedge clk); #1;
    chk("midrst_eng_rst_hold", eng_rst, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    load_tile(KERN_ONES);
    get_results(EXP_ONES, 0, 0, 65);

    // engine never reports done
    done_in = 1'b0;
    load_tile(KERN_ONES);
    begin
      int err_cyc;
      bit saw_valid;
      err_cyc = -1;
      saw_valid = 1'b0;
`ifdef CONV_FEED_TIMEOUT_EN
      for (int c = 0; c < 400 && err_cyc < 0; c++) begin
        if (m_valid) saw_valid = 1'b1;
        if (err_timeout) err_cyc = c;
        @(posedge clk); #1;
      end
      chk("timeout_cycle", err_cyc, 255);
      chk("timeout_s_ready", s_ready, 1);
      chk("timeout_pulse_len", err_timeout, 0);
      chk("timeout_eng_rst", eng_rst, 1);
      for (int c = 0; c < 10; c++) begin
        if (m_valid) saw_valid = 1'b1;
        @(posedge clk); #1;
      end
      chk("timeout_no_valid", saw_valid, 0);
`else
      for (int c = 0; c < 300; c++) begin
        if (m_valid) saw_valid = 1'b1;
        if (err_timeout && err_cyc < 0) err_cyc = c;
        @(posedge clk); #1;
      end
      chk("wait_no_err", err_cyc, -1);
      chk("wait_no_valid", saw_valid, 0);
      chk("wait_eng_rst", eng_rst, 0);
      get_results(EXP_ONES, 0, 0, 1);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
